// File: rtl/ising_ctrl_pkg.sv
// ising_ctrl_pkg: shared widths, state encoding and helpers for the Ising run controller.
package ising_ctrl_pkg;

   localparam int CNT_W = 32;
   localparam int IDX_W = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      RUN     = 3'd2,
      CAPTURE = 3'd3,
      OUT     = 3'd4
   } state_t;

   // A zero-length run window is promoted to one cycle so the sampler always gets a window.
   function automatic logic [CNT_W-1:0] clamp_min1(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] res;
      if (v == {CNT_W{1'b0}}) begin
         res = {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         res = v;
      end
      return res;
   endfunction

endpackage

// File: rtl/ising_wr_fwd.sv
// ising_wr_fwd: one-entry registered forwarder turning the host weight-write
// handshake into a single-cycle core write strobe with registered addr/data.
module ising_wr_fwd
   import ising_ctrl_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_accept_en,
   input  logic             i_wr_valid,
   input  logic [CNT_W-1:0] i_wr_addr,
   input  logic [CNT_W-1:0] i_wdata,
   output logic             o_wr_ready,
   output logic             o_wready,
   output logic [CNT_W-1:0] o_wr_addr,
   output logic [CNT_W-1:0] o_wdata
);

   logic             r_wr_ready;
   logic             r_wready;
   logic [CNT_W-1:0] r_wr_addr;
   logic [CNT_W-1:0] r_wdata;
   logic             w_fire;

   assign w_fire = i_wr_valid & r_wr_ready;

   // Ready follows the controller's next state; an accepted beat becomes a one-cycle strobe.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ready <= 1'b0;
         r_wready   <= 1'b0;
         r_wr_addr  <= {CNT_W{1'b0}};
         r_wdata    <= {CNT_W{1'b0}};
      end else begin
         r_wr_ready <= i_accept_en;
         r_wready   <= w_fire;
         if (w_fire) begin
            r_wr_addr <= i_wr_addr;
            r_wdata   <= i_wdata;
         end
      end
   end

   assign o_wr_ready = r_wr_ready;
   assign o_wready   = r_wready;
   assign o_wr_addr  = r_wr_addr;
   assign o_wdata    = r_wdata;

endmodule

// File: rtl/ising_run_ctrl.sv
// ising_run_ctrl: run sequencer for the Ising array. Forwards host weight writes,
// then performs cfg_runs anneal runs (reset hold, run window, phase capture) and
// streams each captured phase out on a valid/ready interface.
// Optional feature macro: ISING_CTRL_SWEEP_EN (per-run cutoff sweep).
module ising_run_ctrl
   import ising_ctrl_pkg::*;
#(
   parameter int N             = 3,
   parameter int RST_CYCLES    = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [IDX_W-1:0] i_cfg_runs,
   input  logic [CNT_W-1:0] i_cfg_run_cycles,
   input  logic [CNT_W-1:0] i_cfg_cutoff,
   input  logic [CNT_W-1:0] i_cfg_cutoff_step,
   input  logic             i_wr_valid,
   output logic             o_wr_ready,
   input  logic [CNT_W-1:0] i_wr_addr_in,
   input  logic [CNT_W-1:0] i_wdata_in,
   output logic             o_wready,
   output logic [CNT_W-1:0] o_wr_addr,
   output logic [CNT_W-1:0] o_wdata,
   output logic             o_axi_rstn,
   output logic             o_ising_rstn,
   output logic [CNT_W-1:0] o_counter_max,
   output logic [CNT_W-1:0] o_counter_cutoff,
   input  logic [N-1:0]     i_phase,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [N-1:0]     o_res_phase,
   output logic [IDX_W-1:0] o_res_idx,
   output logic             o_busy,
   output logic             o_done
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W:0]   r_cnt;
   logic [CNT_W:0]   w_cnt_nxt;
   logic [CNT_W:0]   w_run_len;
   logic [IDX_W-1:0] r_runs;
   logic [IDX_W-1:0] w_runs_nxt;
   logic [CNT_W-1:0] r_counter_max;
   logic [CNT_W-1:0] w_cmax_nxt;
   logic [CNT_W-1:0] r_counter_cutoff;
   logic [CNT_W-1:0] w_cut_nxt;
   logic [IDX_W-1:0] r_res_idx;
   logic [IDX_W-1:0] w_idx_nxt;
   logic [N-1:0]     r_res_phase;
   logic [N-1:0]     w_phase_nxt;
   logic             r_res_valid;
   logic             w_valid_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             r_ising_rstn;
   logic             r_axi_rstn;
   logic             w_last_run;

`ifdef ISING_CTRL_SWEEP_EN
   logic [CNT_W-1:0] r_step;
   logic [CNT_W-1:0] w_step_nxt;
`else
   logic             w_step_unused;
   assign w_step_unused = ^i_cfg_cutoff_step;
`endif

   // Run window plus settle time, kept one bit wider so a maximal window cannot wrap.
   assign w_run_len  = {1'b0, r_counter_max} + (CNT_W+1)'(SETTLE_CYCLES);
   assign w_last_run = (({1'b0, r_res_idx} + 17'd1) == {1'b0, r_runs});

   // Sequencer state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and next-value logic; abort outranks every other transition.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_runs_nxt  = r_runs;
      w_cmax_nxt  = r_counter_max;
      w_cut_nxt   = r_counter_cutoff;
      w_idx_nxt   = r_res_idx;
      w_phase_nxt = r_res_phase;
      w_valid_nxt = r_res_valid;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
`ifdef ISING_CTRL_SWEEP_EN
      w_step_nxt  = r_step;
`endif
      if ((r_state != IDLE) && i_abort) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = {(CNT_W+1){1'b0}};
         w_valid_nxt = 1'b0;
         w_busy_nxt  = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  if (i_cfg_runs == {IDX_W{1'b0}}) begin
                     w_done_nxt = 1'b1;
                  end else begin
                     w_state_nxt = CLEAR;
                     w_cnt_nxt   = {(CNT_W+1){1'b0}};
                     w_runs_nxt  = i_cfg_runs;
                     w_cmax_nxt  = clamp_min1(i_cfg_run_cycles);
                     w_cut_nxt   = i_cfg_cutoff;
                     w_idx_nxt   = {IDX_W{1'b0}};
                     w_busy_nxt  = 1'b1;
`ifdef ISING_CTRL_SWEEP_EN
                     w_step_nxt  = i_cfg_cutoff_step;
`endif
                  end
               end else begin
                  w_state_nxt = IDLE;
               end
            end
            CLEAR: begin
               if (r_cnt == (CNT_W+1)'(RST_CYCLES - 1)) begin
                  w_state_nxt = RUN;
                  w_cnt_nxt   = {(CNT_W+1){1'b0}};
               end else begin
                  w_cnt_nxt   = r_cnt + 33'd1;
               end
            end
            RUN: begin
               if (r_cnt == (w_run_len - 33'd1)) begin
                  w_state_nxt = CAPTURE;
                  w_cnt_nxt   = {(CNT_W+1){1'b0}};
               end else begin
                  w_cnt_nxt   = r_cnt + 33'd1;
               end
            end
            CAPTURE: begin
               w_phase_nxt = i_phase;
               w_valid_nxt = 1'b1;
               w_state_nxt = OUT;
            end
            OUT: begin
               if (i_res_ready) begin
                  w_valid_nxt = 1'b0;
                  if (w_last_run) begin
                     w_state_nxt = IDLE;
                     w_busy_nxt  = 1'b0;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = CLEAR;
                     w_cnt_nxt   = {(CNT_W+1){1'b0}};
                     w_idx_nxt   = r_res_idx + 16'd1;
`ifdef ISING_CTRL_SWEEP_EN
                     w_cut_nxt   = r_counter_cutoff + r_step;
`else
                     w_cut_nxt   = r_counter_cutoff;
`endif
                  end
               end else begin
                  w_valid_nxt = 1'b1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_valid_nxt = 1'b0;
               w_busy_nxt  = 1'b0;
            end
         endcase
      end
   end

   // Registered datapath and outputs; array reset is released only while running.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt            <= {(CNT_W+1){1'b0}};
         r_runs           <= {IDX_W{1'b0}};
         r_counter_max    <= {CNT_W{1'b0}};
         r_counter_cutoff <= {CNT_W{1'b0}};
         r_res_idx        <= {IDX_W{1'b0}};
         r_res_phase      <= {N{1'b0}};
         r_res_valid      <= 1'b0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
         r_ising_rstn     <= 1'b0;
         r_axi_rstn       <= 1'b0;
`ifdef ISING_CTRL_SWEEP_EN
         r_step           <= {CNT_W{1'b0}};
`endif
      end else begin
         r_cnt            <= w_cnt_nxt;
         r_runs           <= w_runs_nxt;
         r_counter_max    <= w_cmax_nxt;
         r_counter_cutoff <= w_cut_nxt;
         r_res_idx        <= w_idx_nxt;
         r_res_phase      <= w_phase_nxt;
         r_res_valid      <= w_valid_nxt;
         r_busy           <= w_busy_nxt;
         r_done           <= w_done_nxt;
         r_ising_rstn     <= (w_state_nxt == RUN);
         r_axi_rstn       <= 1'b1;
`ifdef ISING_CTRL_SWEEP_EN
         r_step           <= w_step_nxt;
`endif
      end
   end

   ising_wr_fwd u_wr_fwd (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_accept_en (w_state_nxt == IDLE),
      .i_wr_valid  (i_wr_valid),
      .i_wr_addr   (i_wr_addr_in),
      .i_wdata     (i_wdata_in),
      .o_wr_ready  (o_wr_ready),
      .o_wready    (o_wready),
      .o_wr_addr   (o_wr_addr),
      .o_wdata     (o_wdata)
   );

   assign o_axi_rstn       = r_axi_rstn;
   assign o_ising_rstn     = r_ising_rstn;
   assign o_counter_max    = r_counter_max;
   assign o_counter_cutoff = r_counter_cutoff;
   assign o_res_valid      = r_res_valid;
   assign o_res_phase      = r_res_phase;
   assign o_res_idx        = r_res_idx;
   assign o_busy           = r_busy;
   assign o_done           = r_done;

endmodule
